// File: rtl/online_pkg.sv
// Shared types for the radix-4 online-arithmetic blocks: digit type, collector FSM states
// and the two's-complement width helper.
package online_pkg;

  localparam int RADIX4_DIGIT_BITS = 3;

  typedef logic signed [RADIX4_DIGIT_BITS-1:0] sd4_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_COLLECT = 2'd2
  } coll_state_t;

  // Width of the two's-complement image of an n-digit radix-4 signed-digit word.
  function automatic int tc_width(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/otf_converter.sv
// Radix-4 on-the-fly conversion of MSD-first signed digits into two's complement.
// Q, QM = Q-1 and QM2 = Q-2 are kept, so every digit (even -4) is a pure shift-and-append.
module otf_converter
  import online_pkg::*;
#(
  parameter int W          = 9,
  parameter int RADIX_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  sd4_t         digit,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ZERO_V      = {W{1'b0}};
  localparam logic [W-1:0] MINUS_ONE_V = {W{1'b1}};
  localparam logic [W-1:0] MINUS_TWO_V = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0]      q_r, qm_r, qm2_r;
  logic [W-1:0]      q_base_s, qm_base_s, qm2_base_s;
  logic [W-1:0]      q_next_s, qm_next_s, qm2_next_s;
  logic signed [4:0] d_ext_s;

  // Pick the base register whose shifted value lands s in the appended digit range 0..3.
  function automatic logic [W-1:0] append(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                          input logic [W-1:0] b2, input logic signed [4:0] s);
    if (s >= 5'sd0) begin
      return {b0[W-1-RADIX_LOG2:0], s[RADIX_LOG2-1:0]};
    end else if (s >= -5'sd4) begin
      return {b1[W-1-RADIX_LOG2:0], s[RADIX_LOG2-1:0]};
    end else begin
      return {b2[W-1-RADIX_LOG2:0], s[RADIX_LOG2-1:0]};
    end
  endfunction

  // Next-value selection; clear restarts from Q = 0 in the same cycle as the digit.
  always_comb begin
    d_ext_s = {{2{digit[RADIX4_DIGIT_BITS-1]}}, digit};
    if (clear) begin
      q_base_s   = ZERO_V;
      qm_base_s  = MINUS_ONE_V;
      qm2_base_s = MINUS_TWO_V;
    end else begin
      q_base_s   = q_r;
      qm_base_s  = qm_r;
      qm2_base_s = qm2_r;
    end
    q_next_s   = append(q_base_s, qm_base_s, qm2_base_s, d_ext_s);
    qm_next_s  = append(q_base_s, qm_base_s, qm2_base_s, d_ext_s - 5'sd1);
    qm2_next_s = append(q_base_s, qm_base_s, qm2_base_s, d_ext_s - 5'sd2);
  end

  // Conversion register pair (plus Q-2) update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= ZERO_V;
      qm_r  <= MINUS_ONE_V;
      qm2_r <= MINUS_TWO_V;
    end else if (en) begin
      q_r   <= q_next_s;
      qm_r  <= qm_next_s;
      qm2_r <= qm2_next_s;
    end else if (clear) begin
      q_r   <= ZERO_V;
      qm_r  <= MINUS_ONE_V;
      qm2_r <= MINUS_TWO_V;
    end else begin
      q_r   <= q_r;
      qm_r  <= qm_r;
      qm2_r <= qm2_r;
    end
  end

  // Look-ahead Q: the value including the digit applied this cycle.
  assign q = q_next_s;

endmodule

// File: rtl/online_digit_collector.sv
// Receive end of a radix-4 online digit stream: skips the online delay, collects the frame
// and presents signed-digit and two's-complement results. ONLINE_DIGIT_CHECK_EN flags digit -4.
module online_digit_collector
  import online_pkg::*;
#(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int radix        = 4,
  parameter int delta        = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [radix_bits-1:0]               z,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [no_of_digits*radix_bits-1:0]  dout_sd,
  output logic [2*no_of_digits:0]             dout_tc,
  output logic                                overrun,
  output logic                                digit_err
);

  localparam int SDW = no_of_digits * radix_bits;
  localparam int TCW = tc_width(no_of_digits);
  localparam int CW  = $clog2(no_of_digits) + 1;
  localparam logic [CW-1:0]         DIG_ZERO = CW'(0);
  localparam logic [CW-1:0]         DIG_ONE  = CW'(1);
  localparam logic [CW-1:0]         DIG_LAST = CW'(no_of_digits - 1);
  localparam logic [radix_bits-1:0] MOST_NEG = {1'b1, {(radix_bits-1){1'b0}}};

  coll_state_t     state_r, state_nxt_s;
  logic [3:0]      skip_cnt_r, skip_nxt_s;
  logic [CW-1:0]   dig_cnt_r, dig_nxt_s;
  logic            fresh_r, fresh_nxt_s;
  logic [SDW-1:0]  sd_shift_r, sd_next_s;
  logic            capture_s, clear_s, done_s, bad_digit_s;
  sd4_t            conv_digit_s;
  logic [TCW-1:0]  conv_q_s;

  logic            out_valid_r, overrun_r, digit_err_r;
  logic [SDW-1:0]  dout_sd_r;
  logic [TCW-1:0]  dout_tc_r;

`ifdef ONLINE_DIGIT_CHECK_EN
  assign bad_digit_s = capture_s && (z == MOST_NEG);
`else
  assign bad_digit_s = 1'b0;
`endif

  // An illegal digit is kept in the raw word but contributes nothing to the value.
  assign conv_digit_s = bad_digit_s ? 3'sd0 : sd4_t'(z);
  assign sd_next_s    = {sd_shift_r[SDW-radix_bits-1:0], z};

  // Next-state logic; a start in any state restarts frame timing from this cycle.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    dig_nxt_s   = dig_cnt_r;
    fresh_nxt_s = fresh_r;
    capture_s   = 1'b0;
    clear_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_IDLE;
      end
      ST_SKIP: begin
        if (skip_cnt_r == 4'd0) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          skip_nxt_s = skip_cnt_r - 4'd1;
        end
      end
      ST_COLLECT: begin
        capture_s   = 1'b1;
        clear_s     = fresh_r;
        fresh_nxt_s = 1'b0;
        dig_nxt_s   = dig_cnt_r + DIG_ONE;
        if (dig_cnt_r == DIG_LAST) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
          dig_nxt_s   = DIG_ZERO;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // The conversion registers are cleared lazily at the first capture, so a frame
    // completing in the start cycle still finishes on its own Q/QM.
    if (start) begin
      dig_nxt_s   = DIG_ZERO;
      fresh_nxt_s = 1'b1;
      if (delta == 0) begin
        state_nxt_s = ST_COLLECT;
        if (!done_s) begin
          capture_s   = 1'b1;
          clear_s     = 1'b1;
          fresh_nxt_s = 1'b0;
          dig_nxt_s   = DIG_ONE;
        end else begin
          fresh_nxt_s = 1'b1;
        end
      end else if (delta == 1) begin
        state_nxt_s = ST_COLLECT;
      end else begin
        state_nxt_s = ST_SKIP;
        skip_nxt_s  = 4'(delta - 2);
      end
    end else begin
      fresh_nxt_s = fresh_nxt_s;
    end
  end

  // FSM, counters and the raw digit shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      skip_cnt_r <= 4'd0;
      dig_cnt_r  <= DIG_ZERO;
      fresh_r    <= 1'b0;
      sd_shift_r <= {SDW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      skip_cnt_r <= skip_nxt_s;
      dig_cnt_r  <= dig_nxt_s;
      fresh_r    <= fresh_nxt_s;
      if (capture_s) begin
        sd_shift_r <= sd_next_s;
      end
    end
  end

  otf_converter #(
    .W          (TCW),
    .RADIX_LOG2 ($clog2(radix))
  ) u_otf (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .en    (capture_s),
    .digit (conv_digit_s),
    .q     (conv_q_s)
  );

  // Result registers, valid/ready handshake and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      digit_err_r <= 1'b0;
      dout_sd_r   <= {SDW{1'b0}};
      dout_tc_r   <= {TCW{1'b0}};
    end else begin
      if (done_s) begin
        dout_sd_r   <= sd_next_s;
        dout_tc_r   <= conv_q_s;
        out_valid_r <= 1'b1;
        if (out_valid_r && !out_ready) begin
          overrun_r <= 1'b1;
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (bad_digit_s) begin
        digit_err_r <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign dout_sd   = dout_sd_r;
  assign dout_tc   = dout_tc_r;
  assign overrun   = overrun_r;
  assign digit_err = digit_err_r;

endmodule

// File: tb/tb_online_digit_collector.sv
// Directed bench for online_digit_collector (N=4, delta=2); honours ONLINE_DIGIT_CHECK_EN.
module tb_online_digit_collector;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [2:0]  z;
  logic        out_valid, overrun, digit_err;
  logic [11:0] dout_sd;
  logic [8:0]  dout_tc;
  int          tests_run = 0;
  int          tests_failed = 0;

  online_digit_collector #(
    .no_of_digits (4),
    .radix_bits   (3),
    .radix        (4),
    .delta        (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .z         (z),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout_sd   (dout_sd),
    .dout_tc   (dout_tc),
    .overrun   (overrun),
    .digit_err (digit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // start at negedge t, digits at t+2..t+5; returns at the negedge of t+5.
  task automatic drive_frame(input logic [11:0] sd);
    @(negedge clk); start = 1'b1; z = 3'b000;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      z = sd[11-3*j -: 3];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; z = 3'b000; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run += 5;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (dout_sd !== 12'h000) begin tests_failed++; $display("FAIL reset_sd: got %h expected 000", dout_sd); end
    if (dout_tc !== 9'h000) begin tests_failed++; $display("FAIL reset_tc: got %h expected 000", dout_tc); end
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    if (digit_err !== 1'b0) begin tests_failed++; $display("FAIL reset_digit_err: got %b expected 0", digit_err); end
    rst = 1'b0;
  endtask

  task automatic test_values();
    logic [11:0] sd_tab[4];
    logic [8:0]  tc_tab[4];
    sd_tab = '{12'h298, 12'hEC6, 12'hB6D, 12'h6DB};
    tc_tab = '{9'd108, 9'h1EE, 9'h101, 9'h0FF};
    for (int i = 0; i < 4; i++) begin
      drive_frame(sd_tab[i]);
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL value%0d_early_valid: got %b expected 0", i, out_valid); end
      @(negedge clk); z = 3'b000;
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL value%0d_valid: got %b expected 1", i, out_valid); end
      if (dout_sd !== sd_tab[i]) begin tests_failed++; $display("FAIL value%0d_sd: got %h expected %h", i, dout_sd, sd_tab[i]); end
      if (dout_tc !== tc_tab[i]) begin tests_failed++; $display("FAIL value%0d_tc: got %h expected %h", i, dout_tc, tc_tab[i]); end
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL value%0d_consume: got %b expected 0", i, out_valid); end
      @(negedge clk);
    end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL values_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back_overrun();
    out_ready = 1'b0;
    drive_frame(12'h298);
    drive_frame(12'h6DB);
    tests_run += 3;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_valid: got %b expected 1", out_valid); end
    if (dout_sd !== 12'h298) begin tests_failed++; $display("FAIL b2b_first_sd: got %h expected 298", dout_sd); end
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_early_overrun: got %b expected 0", overrun); end
    @(negedge clk); z = 3'b000;
    tests_run += 4;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_valid: got %b expected 1", out_valid); end
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
    if (dout_sd !== 12'h6DB) begin tests_failed++; $display("FAIL b2b_second_sd: got %h expected 6db", dout_sd); end
    if (dout_tc !== 9'h0FF) begin tests_failed++; $display("FAIL b2b_second_tc: got %h expected 0ff", dout_tc); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_consume: got %b expected 0", out_valid); end
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun_sticky: got %b expected 1", overrun); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun_rst: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back_ready();
    out_ready = 1'b1;
    drive_frame(12'h298);
    drive_frame(12'hEC6);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rdy_gap_valid: got %b expected 0", out_valid); end
    @(negedge clk); z = 3'b000;
    tests_run += 2;
    if (dout_tc !== 9'h1EE) begin tests_failed++; $display("FAIL rdy_second_tc: got %h expected 1ee", dout_tc); end
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rdy_overrun: got %b expected 0", overrun); end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rdy_second_valid: got %b expected 1", out_valid); end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rdy_consume: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    drive_frame(12'h298);
    @(negedge clk); z = 3'b000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); z = 3'b001;
    @(negedge clk); z = 3'b010; rst = 1'b1;
    @(negedge clk); z = 3'b000; rst = 1'b0;
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mrst_valid: got %b expected 0", out_valid); end
    if (dout_sd !== 12'h000) begin tests_failed++; $display("FAIL mrst_sd: got %h expected 000", dout_sd); end
    if (dout_tc !== 9'h000) begin tests_failed++; $display("FAIL mrst_tc: got %h expected 000", dout_tc); end
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL mrst_overrun: got %b expected 0", overrun); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mrst_no_valid%0d: got %b expected 0", k, out_valid); end
    end
    drive_frame(12'hB6D);
    @(negedge clk); z = 3'b000;
    tests_run += 3;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mrst_after_valid: got %b expected 1", out_valid); end
    if (dout_sd !== 12'hB6D) begin tests_failed++; $display("FAIL mrst_after_sd: got %h expected b6d", dout_sd); end
    if (dout_tc !== 9'h101) begin tests_failed++; $display("FAIL mrst_after_tc: got %h expected 101", dout_tc); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_restart();
    @(negedge clk); start = 1'b1; z = 3'b000;
    @(negedge clk); start = 1'b0;
    @(negedge clk); z = 3'b011;
    @(negedge clk); z = 3'b011;
    drive_frame(12'h298);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_aborted_valid: got %b expected 0", out_valid); end
    @(negedge clk); z = 3'b000;
    tests_run += 4;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL restart_valid: got %b expected 1", out_valid); end
    if (dout_sd !== 12'h298) begin tests_failed++; $display("FAIL restart_sd: got %h expected 298", dout_sd); end
    if (dout_tc !== 9'd108) begin tests_failed++; $display("FAIL restart_tc: got %h expected 06c", dout_tc); end
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL restart_overrun: got %b expected 0", overrun); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_single: got %b expected 0", out_valid); end
  endtask

  task automatic test_bad_digit();
    logic [8:0] exp_tc;
    logic       exp_err;
`ifdef ONLINE_DIGIT_CHECK_EN
    exp_tc = 9'd64; exp_err = 1'b1;
`else
    exp_tc = 9'd0;  exp_err = 1'b0;
`endif
    drive_frame(12'h300);
    @(negedge clk); z = 3'b000;
    tests_run += 4;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bad_valid: got %b expected 1", out_valid); end
    if (dout_sd !== 12'h300) begin tests_failed++; $display("FAIL bad_sd: got %h expected 300", dout_sd); end
    if (dout_tc !== exp_tc) begin tests_failed++; $display("FAIL bad_tc: got %h expected %h", dout_tc, exp_tc); end
    if (digit_err !== exp_err) begin tests_failed++; $display("FAIL bad_digit_err: got %b expected %b", digit_err, exp_err); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back_overrun();
    test_back_to_back_ready();
    test_mid_reset();
    test_restart();
    test_bad_digit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
